// File: rtl/ibuf_byte_queue.sv
// Instruction byte buffer: circular byte store filled 4 bytes at a time from
// the I-cache path, presenting a 7-byte decode window at the oldest valid
// byte and retiring bytes with the one-hot length returned by the index adders.
module ibuf_byte_queue #(
    parameter int DEPTH      = 16,
    parameter int FILL_BYTES = 4,
    parameter int WIN_BYTES  = 7
) (
    input  logic                          clk,
    input  logic                          reset_l,
    input  logic                          flush,
    input  logic                          fill_valid,
    input  logic [8*FILL_BYTES-1:0]       fill_data,
    output logic                          fill_ready,
    input  logic [WIN_BYTES:0]            consume_oh,
    output logic [8*WIN_BYTES-1:0]        win_data,
    output logic [WIN_BYTES-1:0]          win_valid,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          consume_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [7:0]       store_q [DEPTH];

    logic             fill_acc;
    logic             cons_legal;
    logic [CNT_W-1:0] cons_k;

    // Space check uses the registered count only, so a same-cycle consume
    // never opens room for a fill and there is no input-to-ready path.
    assign fill_ready = (count_q <= CNT_W'(DEPTH - FILL_BYTES));
    assign fill_acc   = fill_valid & fill_ready & ~flush;

    // Decode the advance amount; zero, multi-hot or over-count requests are rejected.
    always_comb begin
        cons_k = '0;
        for (int i = 0; i <= WIN_BYTES; i++) begin
            if (consume_oh[i]) begin
                cons_k = CNT_W'(i);
            end
        end
        cons_legal = $onehot(consume_oh) && (cons_k <= count_q);
    end

    // Next-state for pointers, occupancy and the error pulse; flush wins over all.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (cons_legal) begin
                rd_ptr_d = rd_ptr_q + cons_k[PTR_W-1:0];
            end
            if (fill_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(FILL_BYTES);
            end
            count_d = count_q
                    + (fill_acc   ? CNT_W'(FILL_BYTES) : '0)
                    - (cons_legal ? cons_k             : '0);
            err_d   = ~cons_legal;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Byte store write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (fill_acc) begin
            for (int j = 0; j < FILL_BYTES; j++) begin
                store_q[wr_ptr_q + PTR_W'(j)] <= fill_data[8*j +: 8];
            end
        end
    end

    // Decode window: byte i reads rd_ptr+i (wrapping), masked to zero past count.
    generate
        for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_win
            logic [PTR_W-1:0] idx;
            assign idx                 = rd_ptr_q + PTR_W'(gi);
            assign win_valid[gi]       = (count_q > CNT_W'(gi));
            assign win_data[8*gi +: 8] = win_valid[gi] ? store_q[idx] : 8'h00;
        end
    endgenerate

    assign count       = count_q;
    assign consume_err = err_q;

endmodule

// File: tb/tb_ibuf_byte_queue.sv
// Bench for ibuf_byte_queue: a byte-queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_ibuf_byte_queue;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        flush;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        fill_ready;
    logic [7:0]  consume_oh;
    logic [55:0] win_data;
    logic [6:0]  win_valid;
    logic [4:0]  count;
    logic        consume_err;

    int checks   = 0;
    int failures = 0;

    ibuf_byte_queue dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .flush       (flush),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_ready  (fill_ready),
        .consume_oh  (consume_oh),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .count       (count),
        .consume_err (consume_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: a plain FIFO of bytes -------------
    logic [7:0] mq[$];
    logic       m_err = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_l);
            if (!reset_l) begin
                mq.delete();
                m_err = 1'b0;
            end else begin
                int  n;
                int  k;
                bit  legal;
                bit  room;
                n    = 0;
                k    = 0;
                room = (mq.size() <= 12);
                if (flush) begin
                    mq.delete();
                    m_err = 1'b0;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        if (consume_oh[i]) begin
                            n++;
                            k = i;
                        end
                    end
                    legal = (n == 1) && (k <= mq.size());
                    if (legal) begin
                        for (int i = 0; i < k; i++) void'(mq.pop_front());
                    end
                    if (fill_valid && room) begin
                        for (int j = 0; j < 4; j++) mq.push_back(fill_data[8*j +: 8]);
                    end
                    m_err = !legal;
                end
            end
        end
    end

    function automatic logic [55:0] m_win();
        logic [55:0] w;
        w = '0;
        for (int i = 0; i < 7; i++) begin
            if (i < mq.size()) w[8*i +: 8] = mq[i];
        end
        return w;
    endfunction

    function automatic logic [6:0] m_valid();
        logic [6:0] v;
        v = '0;
        for (int i = 0; i < 7; i++) v[i] = (i < mq.size());
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare process: DUT vs model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_count",       64'(count),       64'(mq.size()));
            chk("model_fill_ready",  64'(fill_ready),  64'(mq.size() <= 12));
            chk("model_win_valid",   64'(win_valid),   64'(m_valid()));
            chk("model_win_data",    64'(win_data),    64'(m_win()));
            chk("model_consume_err", 64'(consume_err), 64'(m_err));
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic step(input logic fv, input logic [31:0] fd,
                        input logic [7:0] coh, input logic fl);
        fill_valid = fv;
        fill_data  = fd;
        consume_oh = coh;
        flush      = fl;
        @(posedge clk);
        #2;
        $display("txn fv=%0d fd=%08h coh=%02h fl=%0d -> count=%0d win=%014h vld=%02h rdy=%0d err=%0d",
                 fv, fd, coh, fl, count, win_data, win_valid, fill_ready, consume_err);
    endtask

    initial begin
        reset_l    = 1'b0;
        flush      = 1'b0;
        fill_valid = 1'b0;
        fill_data  = '0;
        consume_oh = 8'h01;
        #1;
        chk("rst_count",      64'(count),       64'd0);
        chk("rst_fill_ready", 64'(fill_ready),  64'd1);
        chk("rst_win_valid",  64'(win_valid),   64'd0);
        chk("rst_win_data",   64'(win_data),    64'd0);
        chk("rst_err",        64'(consume_err), 64'd0);
        #11 reset_l = 1'b1;

        // 1: four fills to full
        step(1, 32'h03020100, 8'h01, 0);
        step(1, 32'h07060504, 8'h01, 0);
        step(1, 32'h0B0A0908, 8'h01, 0);
        step(1, 32'h0F0E0D0C, 8'h01, 0);
        chk("t1_count",      64'(count),      64'd16);
        chk("t1_fill_ready", 64'(fill_ready), 64'd0);
        chk("t1_win_data",   64'(win_data),   64'h06050403020100);
        chk("t1_win_valid",  64'(win_valid),  64'h7F);
        step(1, 32'hDEADBEEF, 8'h01, 0);     // dropped, no error
        chk("t1_drop_count", 64'(count),       64'd16);
        chk("t1_drop_err",   64'(consume_err), 64'd0);

        // 2: down to 12, then fill + consume 3 together
        step(0, 32'h0, 8'h10, 0);
        chk("t2_count12",    64'(count),      64'd12);
        chk("t2_ready12",    64'(fill_ready), 64'd1);
        chk("t2_win12",      64'(win_data),   64'h0A090807060504);
        step(1, 32'h13121110, 8'h08, 0);
        chk("t2_count13",    64'(count),      64'd13);
        chk("t2_win13",      64'(win_data),   64'h0D0C0B0A090807);

        // 3: window across the wrap
        step(0, 32'h0, 8'h80, 0);
        chk("t3_count6",     64'(count),      64'd6);
        chk("t3_win_old_wr", 64'(win_data),   64'h00131211100F0E);
        chk("t3_valid6",     64'(win_valid),  64'h3F);
        step(1, 32'h17161514, 8'h01, 0);
        chk("t3_win_wrap",   64'(win_data),   64'h14131211100F0E);
        chk("t3_count10",    64'(count),      64'd10);
        step(0, 32'h0, 8'h80, 0);
        chk("t3_count3",     64'(count),      64'd3);
        chk("t3_valid3",     64'(win_valid),  64'h07);
        chk("t3_win3",       64'(win_data),   64'h00000000171615);

        // 4: illegal consumes
        step(0, 32'h0, 8'h02, 0);
        chk("t4_count2",     64'(count),       64'd2);
        step(0, 32'h0, 8'h10, 0);
        chk("t4_over_err",   64'(consume_err), 64'd1);
        chk("t4_over_count", 64'(count),       64'd2);
        step(0, 32'h0, 8'h06, 0);
        chk("t4_multi_err",  64'(consume_err), 64'd1);
        chk("t4_multi_win",  64'(win_data),    64'h00000000001716);
        step(0, 32'h0, 8'h01, 0);
        chk("t4_idle_err",   64'(consume_err), 64'd0);
        step(0, 32'h0, 8'h00, 0);
        chk("t4_zero_err",   64'(consume_err), 64'd1);
        step(0, 32'h0, 8'h04, 0);            // k == count, legal
        chk("t4_eq_err",     64'(consume_err), 64'd0);
        chk("t4_eq_count",   64'(count),       64'd0);

        // 5: flush beats fill, consume and a pending error
        step(1, 32'h23222120, 8'h01, 0);
        step(0, 32'h0, 8'h00, 0);
        chk("t5_pre_err",    64'(consume_err), 64'd1);
        step(1, 32'h55555555, 8'h02, 1);
        chk("t5_count",      64'(count),       64'd0);
        chk("t5_valid",      64'(win_valid),   64'd0);
        chk("t5_data",       64'(win_data),    64'd0);
        chk("t5_ready",      64'(fill_ready),  64'd1);
        chk("t5_err",        64'(consume_err), 64'd0);

        // 6: asynchronous reset mid-stream
        step(1, 32'h33323130, 8'h01, 0);
        step(1, 32'h37363534, 8'h01, 0);
        chk("t6_pre_win",    64'(win_data),    64'h36353433323130);
        fill_valid = 1'b0;
        consume_oh = 8'h01;
        #1 reset_l = 1'b0;
        #1;
        chk("t6_async_count", 64'(count),      64'd0);
        chk("t6_async_valid", 64'(win_valid),  64'd0);
        chk("t6_async_data",  64'(win_data),   64'd0);
        chk("t6_async_ready", 64'(fill_ready), 64'd1);
        #3 reset_l = 1'b1;
        step(1, 32'h43424140, 8'h01, 0);
        chk("t6_post_count", 64'(count),       64'd4);
        chk("t6_post_win",   64'(win_data),    64'h00000043424140);
        step(0, 32'h0, 8'h01, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
